// File: rtl/cell_unit_gen.sv
// rtl/cell_unit_gen.sv - board-cell move generator: seeds its piece, relays tokens, queues move records
module cell_unit_gen #(
    parameter  int CW         = 3,
    parameter  int FIFO_DEPTH = 4,
    localparam int RW         = 2*CW+3,
    localparam int MW         = 4*CW+4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            newboard,
    input  logic [CW-1:0]   xpos,
    input  logic [CW-1:0]   ypos,
    input  logic [3:0]      cpiece,
    input  logic [8*RW-1:0] ray_in,
    output logic [8*RW-1:0] ray_out,
    input  logic [8*RW-1:0] knight_in,
    output logic [8*RW-1:0] knight_out,
    output logic            mv_valid,
    input  logic            mv_ready,
    output logic [MW-1:0]   mv_data,
    output logic            busy,
    output logic            done
);
    localparam int MAX_HOPS = (1 << CW) - 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [2:0] T_EMPTY  = 3'd0;
    localparam logic [2:0] T_PAWN   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic [2:0] T_BISHOP = 3'd3;
    localparam logic [2:0] T_ROOK   = 3'd4;
    localparam logic [2:0] T_QUEEN  = 3'd5;
    localparam logic [2:0] T_KING   = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_SEED, S_PROP, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [3:0]        piece_q, piece_d;
    logic [CW-1:0]     hop_q, hop_d;
    logic [8*RW-1:0]   ray_out_q, ray_out_d;
    logic [8*RW-1:0]   knight_out_q, knight_out_d;
    logic [15:0]       slot_full_q, slot_used_q, cand_v;
    logic [MW-1:0]     slot_rec_q [16];
    logic [MW-1:0]     cand_rec [16];
    logic [MW-1:0]     fifo_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q;
    logic [3:0]        pick;
    logic              pick_v, push, pop, drained;
    logic              cell_empty, cell_black;
    logic [RW-1:0]     seed_tok;
    logic [2:0]        rt;

    assign cell_empty = (piece_q[2:0] == T_EMPTY);
    assign cell_black = piece_q[3] && !cell_empty;
    assign seed_tok   = {xpos, ypos, piece_q[2:0]};

    // Every candidate record is formed unconditionally; cand_v decides whether a slot takes it.
    always_comb begin
        for (int d = 0; d < 8; d++) begin
            cand_rec[d]   = {ray_in[d*RW+3 +: 2*CW], xpos, ypos, ray_in[d*RW +: 3], cell_black};
            cand_rec[8+d] = {knight_in[d*RW+3 +: 2*CW], xpos, ypos, knight_in[d*RW +: 3], cell_black};
        end
    end

    always_comb begin
        state_d      = state_q;
        piece_d      = piece_q;
        hop_d        = hop_q;
        ray_out_d    = '0;
        knight_out_d = '0;
        cand_v       = '0;
        rt           = '0;
        case (state_q)
            S_IDLE: begin
                if (newboard) begin
                    state_d = S_SEED;
                    piece_d = cpiece;
                end
            end
            S_SEED: begin
                state_d = S_PROP;
                hop_d   = '0;
                if (!piece_q[3] && !cell_empty) begin
                    case (piece_q[2:0])
                        T_PAWN: begin
                            ray_out_d[0*RW +: RW] = seed_tok;
                            ray_out_d[1*RW +: RW] = seed_tok;
                            ray_out_d[7*RW +: RW] = seed_tok;
                        end
                        T_KNIGHT: knight_out_d = {8{seed_tok}};
                        T_BISHOP: for (int d = 1; d < 8; d += 2) ray_out_d[d*RW +: RW] = seed_tok;
                        T_ROOK:   for (int d = 0; d < 8; d += 2) ray_out_d[d*RW +: RW] = seed_tok;
                        T_QUEEN, T_KING: ray_out_d = {8{seed_tok}};
                        default: ;
                    endcase
                end
            end
            S_PROP: begin
                hop_d = hop_q + CW'(1);
                if (hop_q == CW'(MAX_HOPS-1)) state_d = S_DRAIN;
                for (int d = 0; d < 8; d++) begin
                    rt = ray_in[d*RW +: 3];
                    if (rt == T_PAWN) begin
                        // Double push is relayed only from the square directly ahead of rank 1.
                        if (d == 0 && cell_empty) begin
                            cand_v[d] = 1'b1;
                            if (ray_in[d*RW+3 +: CW] == CW'(1) && ypos == CW'(2))
                                ray_out_d[d*RW +: RW] = ray_in[d*RW +: RW];
                        end else if ((d == 1 || d == 7) && cell_black) begin
                            cand_v[d] = 1'b1;
                        end
                    end else if (rt != T_EMPTY && (cell_empty || cell_black)) begin
                        cand_v[d] = 1'b1;
                        if (cell_empty && ((rt == T_QUEEN) ||
                                           (rt == T_BISHOP && (d % 2) == 1) ||
                                           (rt == T_ROOK && (d % 2) == 0)))
                            ray_out_d[d*RW +: RW] = ray_in[d*RW +: RW];
                    end
                    if (knight_in[d*RW +: 3] != T_EMPTY && (cell_empty || cell_black))
                        cand_v[8+d] = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drained) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pick_v = 1'b0;
        pick   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (slot_full_q[i]) begin
                pick_v = 1'b1;
                pick   = 4'(i);
            end
        end
    end

    assign mv_valid   = (cnt_q != '0);
    assign pop        = mv_valid && mv_ready;
    assign push       = pick_v && ((cnt_q != (AW+1)'(FIFO_DEPTH)) || pop);
    assign drained    = (slot_full_q == '0) && (cnt_q == '0);
    assign mv_data    = mv_valid ? fifo_q[rd_ptr_q] : '0;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DRAIN) && drained;
    assign ray_out    = ray_out_q;
    assign knight_out = knight_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            piece_q      <= '0;
            hop_q        <= '0;
            ray_out_q    <= '0;
            knight_out_q <= '0;
            slot_full_q  <= '0;
            slot_used_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < 16; i++) slot_rec_q[i] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            piece_q      <= piece_d;
            hop_q        <= hop_d;
            ray_out_q    <= ray_out_d;
            knight_out_q <= knight_out_d;
            if (state_q == S_SEED) slot_used_q <= '0;
            for (int i = 0; i < 16; i++) begin
                if (push && pick == 4'(i)) slot_full_q[i] <= 1'b0;
                if (cand_v[i] && !slot_used_q[i]) begin
                    slot_full_q[i] <= 1'b1;
                    slot_used_q[i] <= 1'b1;
                    slot_rec_q[i]  <= cand_rec[i];
                end
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= slot_rec_q[pick];
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_cell_unit_gen.sv
// tb/tb_cell_unit_gen.sv - directed self-checking bench for cell_unit_gen
module tb_cell_unit_gen;
    localparam int CW = 3;
    localparam int RW = 2*CW+3;
    localparam int MW = 4*CW+4;
    localparam logic [2:0] T_PAWN   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic [2:0] T_BISHOP = 3'd3;
    localparam logic [2:0] T_ROOK   = 3'd4;
    localparam logic [2:0] T_QUEEN  = 3'd5;
    localparam logic [2:0] T_KING   = 3'd6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            newboard = 1'b0;
    logic [CW-1:0]   xpos = '0;
    logic [CW-1:0]   ypos = '0;
    logic [3:0]      cpiece = '0;
    logic [8*RW-1:0] ray_in = '0;
    logic [8*RW-1:0] ray_out;
    logic [8*RW-1:0] knight_in = '0;
    logic [8*RW-1:0] knight_out;
    logic            mv_valid;
    logic            mv_ready = 1'b0;
    logic [MW-1:0]   mv_data;
    logic            busy;
    logic            done;

    int vectors = 0;
    int miscompares = 0;

    cell_unit_gen #(.CW(CW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .newboard(newboard), .xpos(xpos), .ypos(ypos),
        .cpiece(cpiece), .ray_in(ray_in), .ray_out(ray_out), .knight_in(knight_in),
        .knight_out(knight_out), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_data(mv_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] tok(input logic [2:0] x, input logic [2:0] y, input logic [2:0] t);
        return {x, y, t};
    endfunction

    function automatic logic [MW-1:0] rec(input logic [2:0] fx, input logic [2:0] fy,
                                          input logic [2:0] tx, input logic [2:0] ty,
                                          input logic [2:0] t, input logic c);
        return {fx, fy, tx, ty, t, c};
    endfunction

    // Returns at the negedge where the FSM sits in SEED.
    task automatic start_board(input logic [3:0] pc, input logic [2:0] x, input logic [2:0] y);
        @(negedge clk);
        xpos = x; ypos = y; cpiece = pc; newboard = 1'b1;
        @(negedge clk);
        newboard = 1'b0;
    endtask

    task automatic wait_rec(output logic [MW-1:0] data, output bit ok);
        ok = 1'b0;
        data = '0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (mv_valid) begin
                ok = 1'b1;
                data = mv_data;
                mv_ready = 1'b1;
                @(negedge clk);
                mv_ready = 1'b0;
            end
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mv_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000", {mv_valid, busy, done});
        end
        vectors++;
        if (ray_out !== '0 || knight_out !== '0) begin
            miscompares++;
            $display("FAIL reset_channels: got %h/%h expected 0/0", ray_out, knight_out);
        end
        vectors++;
        if (mv_data !== '0) begin
            miscompares++;
            $display("FAIL reset_mv_data: got %h expected 0", mv_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_quiet_rook;
        logic [MW-1:0] d;
        logic [8*RW-1:0] e;
        bit ok;
        start_board(4'h0, 3'd0, 3'd3);
        @(negedge clk);
        ray_in[0 +: RW] = tok(3'd0, 3'd0, T_ROOK);
        @(negedge clk);
        ray_in = '0;
        e = '0;
        e[0 +: RW] = tok(3'd0, 3'd0, T_ROOK);
        vectors++;
        if (ray_out !== e) begin
            miscompares++;
            $display("FAIL rook_forward: got %h expected %h", ray_out, e);
        end
        wait_rec(d, ok);
        vectors++;
        if (!ok || d !== rec(3'd0, 3'd0, 3'd0, 3'd3, T_ROOK, 1'b0)) begin
            miscompares++;
            $display("FAIL rook_quiet_rec: got %h (ok=%0d) expected %h", d, ok, rec(3'd0, 3'd0, 3'd0, 3'd3, T_ROOK, 1'b0));
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rook_done: got no pulse expected done");
        end
        @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL rook_idle: got busy,done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_capture;
        logic [MW-1:0] d;
        bit ok;
        start_board({1'b1, T_QUEEN}, 3'd3, 3'd3);
        @(negedge clk);
        ray_in[1*RW +: RW] = tok(3'd1, 3'd1, T_BISHOP);
        @(negedge clk);
        ray_in = '0;
        vectors++;
        if (ray_out !== '0) begin
            miscompares++;
            $display("FAIL capture_no_forward: got %h expected 0", ray_out);
        end
        wait_rec(d, ok);
        vectors++;
        if (!ok || d !== rec(3'd1, 3'd1, 3'd3, 3'd3, T_BISHOP, 1'b1)) begin
            miscompares++;
            $display("FAIL capture_rec: got %h (ok=%0d) expected %h", d, ok, rec(3'd1, 3'd1, 3'd3, 3'd3, T_BISHOP, 1'b1));
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL capture_done: got no pulse expected done");
        end
    endtask

    task automatic test_pawn;
        logic [MW-1:0] d;
        logic [8*RW-1:0] e;
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            start_board(4'h0, 3'd4, 3'(2 + pass));
            @(negedge clk);
            ray_in[0 +: RW]    = tok(3'd4, 3'd1, T_PAWN);
            ray_in[1*RW +: RW] = tok(3'd3, 3'd1, T_PAWN);
            @(negedge clk);
            ray_in = '0;
            e = '0;
            if (pass == 0) e[0 +: RW] = tok(3'd4, 3'd1, T_PAWN);
            vectors++;
            if (ray_out !== e) begin
                miscompares++;
                $display("FAIL pawn_forward_%0d: got %h expected %h", pass, ray_out, e);
            end
            wait_rec(d, ok);
            vectors++;
            if (!ok || d !== rec(3'd4, 3'd1, 3'd4, 3'(2 + pass), T_PAWN, 1'b0)) begin
                miscompares++;
                $display("FAIL pawn_rec_%0d: got %h (ok=%0d) expected %h", pass, d, ok, rec(3'd4, 3'd1, 3'd4, 3'(2 + pass), T_PAWN, 1'b0));
            end
            wait_done(ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL pawn_single_rec_%0d: got no done expected done with no extra record", pass);
            end
        end
    endtask

    task automatic test_seed;
        logic [8*RW-1:0] e;
        bit ok;
        start_board({1'b0, T_ROOK}, 3'd2, 3'd5);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL seed_busy: got %b expected 1", busy);
        end
        @(negedge clk);
        e = '0;
        for (int d = 0; d < 8; d += 2) e[d*RW +: RW] = tok(3'd2, 3'd5, T_ROOK);
        vectors++;
        if (ray_out !== e || knight_out !== '0) begin
            miscompares++;
            $display("FAIL seed_rook: got %h/%h expected %h/0", ray_out, knight_out, e);
        end
        @(negedge clk);
        vectors++;
        if (ray_out !== '0) begin
            miscompares++;
            $display("FAIL seed_one_cycle: got %h expected 0", ray_out);
        end
        wait_done(ok);
        start_board({1'b0, T_KING}, 3'd4, 3'd4);
        @(negedge clk);
        e = {8{tok(3'd4, 3'd4, T_KING)}};
        vectors++;
        if (ray_out !== e || knight_out !== '0) begin
            miscompares++;
            $display("FAIL seed_king: got %h/%h expected %h/0", ray_out, knight_out, e);
        end
        wait_done(ok);
        start_board({1'b0, T_KNIGHT}, 3'd1, 3'd2);
        @(negedge clk);
        e = {8{tok(3'd1, 3'd2, T_KNIGHT)}};
        vectors++;
        if (knight_out !== e || ray_out !== '0) begin
            miscompares++;
            $display("FAIL seed_knight: got %h/%h expected 0/%h", ray_out, knight_out, e);
        end
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL seed_done: got no pulse expected done");
        end
    endtask

    task automatic test_back_to_back;
        logic [MW-1:0] exp_rec [16];
        logic [8*RW-1:0] qin;
        bit ok, got;
        for (int d = 0; d < 8; d++) begin
            exp_rec[d]   = rec(3'(d), 3'd0, 3'd3, 3'd3, T_QUEEN, 1'b0);
            exp_rec[8+d] = rec(3'(d), 3'd1, 3'd3, 3'd3, T_KNIGHT, 1'b0);
        end
        start_board(4'h0, 3'd3, 3'd3);
        @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            ray_in[d*RW +: RW]    = tok(3'(d), 3'd0, T_QUEEN);
            knight_in[d*RW +: RW] = tok(3'(d), 3'd1, T_KNIGHT);
        end
        qin = ray_in;
        @(negedge clk);
        knight_in = '0;
        ray_in = '0;
        ray_in[0 +: RW] = tok(3'd7, 3'd7, T_ROOK);
        vectors++;
        if (ray_out !== qin) begin
            miscompares++;
            $display("FAIL b2b_queen_forward: got %h expected %h", ray_out, qin);
        end
        @(negedge clk);
        ray_in = '0;
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            if (mv_valid) got = 1'b1;
            else @(negedge clk);
        end
        for (int c = 0; c < 30; c++) begin
            vectors++;
            if (mv_valid !== 1'b1 || mv_data !== exp_rec[0] || done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_hold_%0d: got valid=%b data=%h done=%b expected 1/%h/0", c, mv_valid, mv_data, done, exp_rec[0]);
            end
            @(negedge clk);
        end
        mv_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            got = 1'b0;
            for (int w = 0; w < 10 && !got; w++) begin
                if (mv_valid) got = 1'b1;
                else @(negedge clk);
            end
            vectors++;
            if (!got || mv_data !== exp_rec[i]) begin
                miscompares++;
                $display("FAIL b2b_rec_%0d: got %h (valid=%0d) expected %h", i, mv_data, got, exp_rec[i]);
            end
            @(negedge clk);
        end
        mv_ready = 1'b0;
        wait_done(ok);
        vectors++;
        if (!ok || mv_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: got done=%0d valid=%b expected done with empty queue", ok, mv_valid);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_done_pulse: got done,busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        start_board(4'h0, 3'd3, 3'd3);
        @(negedge clk);
        ray_in[2*RW +: RW] = tok(3'd1, 3'd3, T_ROOK);
        ray_in[6*RW +: RW] = tok(3'd6, 3'd3, T_ROOK);
        @(negedge clk);
        ray_in = '0;
        repeat (10) @(negedge clk);
        vectors++;
        if ({mv_valid, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_pre_drain: got valid,busy=%b expected 11", {mv_valid, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({mv_valid, busy, done} !== 3'b000 || mv_data !== '0) begin
            miscompares++;
            $display("FAIL rst_async: got flags=%b data=%h expected 000/0", {mv_valid, busy, done}, mv_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({mv_valid, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_no_stale_%0d: got valid,busy=%b expected 00", c, {mv_valid, busy});
            end
        end
        start_board(4'h0, 3'd3, 3'd3);
        wait_done(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_fresh_eval: got no done expected done with no records");
        end
    endtask

    initial begin
        test_reset();
        test_quiet_rook();
        test_capture();
        test_pawn();
        test_seed();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
